// File: rtl/spram_loader_arb_if.sv
// Bus bundle between spram_loader_arb and its surroundings.
// Groups the load control, the 8-bit byte stream, the client port and the spram
// drive signals. The 'slave' modport is the arbiter's view; the 'master' modport
// is the view of the environment (bridge, client and RAM).
//  start/base_addr/len/busy/done : load control and status
//  s_valid/s_data/s_ready        : byte stream handshake
//  c_req/c_we/c_addr/c_di        : client request
//  c_gnt/c_rvalid/c_rdata        : client response
//  ram_ce/ram_we/ram_addr/ram_di : spram inputs
//  ram_do                        : spram read data
interface spram_loader_arb_if #(
   parameter int unsigned aw = 10,
   parameter int unsigned dw = 32
);
   logic          start;
   logic [aw-1:0] base_addr;
   logic [aw:0]   len;
   logic          busy;
   logic          done;

   logic          s_valid;
   logic [7:0]    s_data;
   logic          s_ready;

   logic          c_req;
   logic          c_we;
   logic [aw-1:0] c_addr;
   logic [dw-1:0] c_di;
   logic          c_gnt;
   logic          c_rvalid;
   logic [dw-1:0] c_rdata;

   logic          ram_ce;
   logic          ram_we;
   logic [aw-1:0] ram_addr;
   logic [dw-1:0] ram_di;
   logic [dw-1:0] ram_do;

   modport slave (
      input  start, base_addr, len, s_valid, s_data,
      input  c_req, c_we, c_addr, c_di, ram_do,
      output busy, done, s_ready, c_gnt, c_rvalid, c_rdata,
      output ram_ce, ram_we, ram_addr, ram_di
   );

   modport master (
      output start, base_addr, len, s_valid, s_data,
      output c_req, c_we, c_addr, c_di, ram_do,
      input  busy, done, s_ready, c_gnt, c_rvalid, c_rdata,
      input  ram_ce, ram_we, ram_addr, ram_di
   );
endinterface

// File: rtl/spram_loader_arb.sv
// Front end for one spram instance.
// Packs an 8-bit valid/ready byte stream into dw-bit little-endian words written to
// consecutive RAM addresses (wrapping modulo 2^aw), and arbitrates that loader against
// a single client port. The loader owns the RAM while busy; the client is granted only
// when the loader is idle or signalling completion. Client reads return one cycle
// after the grant, following the spram read latency.
//  clk  : clock, rising edge
//  rst  : synchronous reset, active high
//  bus  : spram_loader_arb_if.slave (load control, byte stream, client port, spram drive)
module spram_loader_arb #(
   parameter int unsigned aw = 10,
   parameter int unsigned dw = 32
) (
   input  logic               clk,
   input  logic               rst,
   spram_loader_arb_if.slave  bus
);

   localparam int unsigned nb = dw / 8;
   localparam int unsigned bw = (nb > 1) ? $clog2(nb) : 1;
   localparam int unsigned cw = aw + 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic [aw-1:0] base_q;
   logic [cw-1:0] len_q;
   logic [cw-1:0] wcnt;
   logic [cw-1:0] wcnt_inc;
   logic [bw-1:0] bcnt;
   logic [dw-1:0] pack;

   logic          busy_q;
   logic          done_q;
   logic          s_ready_q;
   logic          c_rvalid_q;

   logic          byte_acc;
   logic          last_byte;
   logic          gnt;

   // Stream handshake and word bookkeeping
   assign byte_acc  = bus.s_valid & s_ready_q;
   assign last_byte = (bcnt == bw'(nb - 1));
   assign wcnt_inc  = wcnt + cw'(1);

   // Client may only use the RAM when the loader is not driving it
   assign gnt = bus.c_req & ((state == IDLE) | (state == DONE));

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = (bus.len == '0) ? DONE : LOAD;
         LOAD:    if (byte_acc && last_byte) state_nx = WRITE;
         WRITE:   state_nx = (wcnt_inc == len_q) ? DONE : LOAD;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // RAM port mux: client grant, loader write, or idle
   always_comb begin
      bus.ram_ce   = 1'b0;
      bus.ram_we   = 1'b0;
      bus.ram_addr = bus.c_addr;
      bus.ram_di   = bus.c_di;
      if (gnt) begin
         bus.ram_ce = 1'b1;
         bus.ram_we = bus.c_we;
      end else if (state == WRITE) begin
         bus.ram_ce   = 1'b1;
         bus.ram_we   = 1'b1;
         bus.ram_addr = base_q + wcnt[aw-1:0];
         bus.ram_di   = pack;
      end
   end

   // State register, registered status outputs and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         s_ready_q  <= 1'b0;
         c_rvalid_q <= 1'b0;
         base_q     <= '0;
         len_q      <= '0;
         wcnt       <= '0;
         bcnt       <= '0;
         pack       <= '0;
      end else begin
         state      <= state_nx;
         busy_q     <= (state_nx == LOAD) || (state_nx == WRITE);
         done_q     <= (state_nx == DONE);
         s_ready_q  <= (state_nx == LOAD);
         c_rvalid_q <= gnt & ~bus.c_we;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  base_q <= bus.base_addr;
                  len_q  <= bus.len;
                  wcnt   <= '0;
                  bcnt   <= '0;
               end
            end
            LOAD: begin
               if (byte_acc) begin
                  // Byte k of the word lands in lane k (little-endian)
                  for (int unsigned k = 0; k < nb; k++) begin
                     if (bcnt == bw'(k)) pack[8*k +: 8] <= bus.s_data;
                  end
                  bcnt <= last_byte ? '0 : bcnt + bw'(1);
               end
            end
            WRITE:   wcnt <= wcnt_inc;
            default: ;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.s_ready  = s_ready_q;
   assign bus.c_gnt    = gnt;
   assign bus.c_rvalid = c_rvalid_q;
   assign bus.c_rdata  = bus.ram_do;

endmodule

// File: tb/tb_spram_loader_arb.sv
// Self-checking bench for spram_loader_arb (aw=10, dw=32) with a behavioural spram.
// A transaction-level model predicts the loader word writes, busy/done/s_ready timing,
// client grants and read data; it is checked every cycle, and literal RAM contents pin it.
module tb_spram_loader_arb;

   localparam int unsigned aw = 10;
   localparam int unsigned dw = 32;

   logic clk = 1'b0;
   logic rst;
   logic chk_en = 1'b0;
   int   total = 0;
   int   bad = 0;

   spram_loader_arb_if #(.aw(aw), .dw(dw)) bus ();

   spram_loader_arb #(.aw(aw), .dw(dw)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural spram: 1-cycle read latency
   logic [dw-1:0] mem [1024];
   always @(posedge clk) begin
      if (bus.ram_ce) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
         else            bus.ram_do <= mem[bus.ram_addr];
      end
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // ---------------- transaction-level model ----------------
   typedef struct packed {
      logic [aw-1:0] a;
      logic [dw-1:0] d;
   } wr_t;

   wr_t           wq[$];
   logic [dw-1:0] ref_mem [1024];
   bit            m_busy = 1'b0;
   bit            m_done = 1'b0;
   bit            m_rv = 1'b0;
   logic [aw-1:0] m_raddr;
   logic [aw-1:0] m_base;
   logic [aw:0]   m_len, m_pushed, m_written;
   int            m_bc = 0;
   logic [dw-1:0] m_pack = '0;

   initial begin
      forever begin
         bit  g, rdy, n_busy, n_done;
         wr_t w;
         @(negedge clk);
         g   = bus.c_req && !m_busy;
         rdy = m_busy && (wq.size() == 0);
         if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("s_ready", 32'(bus.s_ready), 32'(rdy));
            chk("c_gnt", 32'(bus.c_gnt), 32'(g));
            chk("c_rvalid", 32'(bus.c_rvalid), 32'(m_rv));
            if (m_rv) chk("c_rdata", bus.c_rdata, ref_mem[m_raddr]);
         end
         n_busy = m_busy;
         n_done = 1'b0;
         if (g) begin
            if (chk_en) begin
               chk("cli ram_ce", 32'(bus.ram_ce), 32'd1);
               chk("cli ram_we", 32'(bus.ram_we), 32'(bus.c_we));
               chk("cli ram_addr", 32'(bus.ram_addr), 32'(bus.c_addr));
               if (bus.c_we) chk("cli ram_di", bus.ram_di, bus.c_di);
            end
            if (bus.c_we) ref_mem[bus.c_addr] = bus.c_di;
         end else if (m_busy && wq.size() != 0) begin
            w = wq.pop_front();
            if (chk_en) begin
               chk("ld ram_ce", 32'(bus.ram_ce), 32'd1);
               chk("ld ram_we", 32'(bus.ram_we), 32'd1);
               chk("ld ram_addr", 32'(bus.ram_addr), 32'(w.a));
               chk("ld ram_di", bus.ram_di, w.d);
            end
            ref_mem[w.a] = w.d;
            m_written++;
            if (m_written == m_len) begin
               n_busy = 1'b0;
               n_done = 1'b1;
            end
         end else if (chk_en) begin
            chk("idle ram_ce", 32'(bus.ram_ce), 32'd0);
            chk("idle ram_we", 32'(bus.ram_we), 32'd0);
         end
         m_rv    = g && !bus.c_we;
         m_raddr = bus.c_addr;
         if (bus.start && !m_busy && !m_done) begin
            m_base    = bus.base_addr;
            m_len     = bus.len;
            m_pushed  = '0;
            m_written = '0;
            m_bc      = 0;
            if (bus.len == '0) n_done = 1'b1;
            else               n_busy = 1'b1;
         end
         if (rdy && bus.s_valid) begin
            m_pack[8*m_bc +: 8] = bus.s_data;
            m_bc++;
            if (m_bc == dw / 8) begin
               w.a = m_base + m_pushed[aw-1:0];
               w.d = m_pack;
               wq.push_back(w);
               m_pushed++;
               m_bc = 0;
            end
         end
         m_busy = n_busy;
         m_done = n_done;
         if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rv   = 1'b0;
            m_bc   = 0;
            m_pack = '0;
            wq.delete();
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [aw-1:0] b, input logic [aw:0] l);
      bus.start     = 1'b1;
      bus.base_addr = b;
      bus.len       = l;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gaps, input bit spulse);
      int t = 0;
      repeat (gaps) tick();
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      if (spulse) begin
         bus.start     = 1'b1;
         bus.base_addr = aw'($urandom);
         bus.len       = (aw+1)'($urandom);
      end
      @(negedge clk);
      while (!bus.s_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("s_ready wait", 32'(bus.s_ready), 32'd1);
      tick();
      bus.s_valid = 1'b0;
      bus.start   = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] wd, input bit rnd);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         b = wd[8*i +: 8];
         if (rnd) send_byte(b, $urandom_range(0, 3), $urandom_range(0, 2) == 0);
         else     send_byte(b, 0, 1'b0);
      end
   endtask

   task automatic wait_done;
      int t = 0;
      @(negedge clk);
      while (!bus.done && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("done wait", 32'(bus.done), 32'd1);
      tick();
   endtask

   task automatic client_read(input logic [aw-1:0] a, input logic [31:0] exp, input string nm);
      bus.c_req  = 1'b1;
      bus.c_we   = 1'b0;
      bus.c_addr = a;
      @(negedge clk);
      chk({nm, " gnt"}, 32'(bus.c_gnt), 32'd1);
      tick();
      bus.c_req = 1'b0;
      @(negedge clk);
      chk({nm, " rvalid"}, 32'(bus.c_rvalid), 32'd1);
      chk({nm, " rdata"}, bus.c_rdata, exp);
      tick();
   endtask

   task automatic client_write(input logic [aw-1:0] a, input logic [31:0] d);
      bus.c_req  = 1'b1;
      bus.c_we   = 1'b1;
      bus.c_addr = a;
      bus.c_di   = d;
      tick();
      bus.c_req = 1'b0;
      bus.c_we  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int t;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.len       = '0;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.c_req     = 1'b0;
      bus.c_we      = 1'b0;
      bus.c_addr    = '0;
      bus.c_di      = '0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst c_rvalid", 32'(bus.c_rvalid), 32'd0);
      tick();

      // 1: two-word load
      do_start(10'h010, 11'd2);
      send_word(32'h44332211, 1'b0);
      send_word(32'h88776655, 1'b0);
      wait_done();
      chk("t1 mem010", mem[10'h010], 32'h44332211);
      chk("t1 mem011", mem[10'h011], 32'h88776655);
      @(negedge clk);
      chk("t1 busy after", 32'(bus.busy), 32'd0);
      tick();

      // 2: zero-length load
      do_start(10'h100, 11'd0);
      @(negedge clk);
      chk("t2 done", 32'(bus.done), 32'd1);
      chk("t2 s_ready", 32'(bus.s_ready), 32'd0);
      tick();

      // 3: wrap, with client read granted in the start cycle
      bus.c_req  = 1'b1;
      bus.c_we   = 1'b0;
      bus.c_addr = 10'h010;
      do_start(10'h3FF, 11'd2);
      bus.c_req = 1'b0;
      @(negedge clk);
      chk("t3 rvalid", 32'(bus.c_rvalid), 32'd1);
      chk("t3 rdata", bus.c_rdata, 32'h44332211);
      tick();
      send_word(32'h04030201, 1'b0);
      send_word(32'h08070605, 1'b0);
      wait_done();
      chk("t3 mem3ff", mem[10'h3FF], 32'h04030201);
      chk("t3 mem000", mem[10'h000], 32'h08070605);

      // 4: client read held during a load
      do_start(10'h100, 11'd1);
      bus.c_req  = 1'b1;
      bus.c_we   = 1'b0;
      bus.c_addr = 10'h011;
      send_word(32'hF0DEBC9A, 1'b0);
      t = 0;
      @(negedge clk);
      while (!bus.c_gnt && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("t4 gnt", 32'(bus.c_gnt), 32'd1);
      chk("t4 gnt in done", 32'(bus.done), 32'd1);
      tick();
      bus.c_req = 1'b0;
      @(negedge clk);
      chk("t4 rvalid", 32'(bus.c_rvalid), 32'd1);
      chk("t4 rdata", bus.c_rdata, 32'h88776655);
      tick();
      client_read(10'h100, 32'hF0DEBC9A, "t4 rd100");
      client_write(10'h200, 32'hDEADBEEF);
      client_read(10'h200, 32'hDEADBEEF, "t4 rd200");
      client_write(10'h050, 32'h5A5A5A5A);

      // 5: stream gaps and start pulses while busy
      do_start(10'h020, 11'd2);
      send_word(32'h44332211, 1'b1);
      send_word(32'h88776655, 1'b1);
      wait_done();
      chk("t5 mem020", mem[10'h020], 32'h44332211);
      chk("t5 mem021", mem[10'h021], 32'h88776655);
      client_read(10'h021, 32'h88776655, "t5 rd021");

      // 6: reset after three bytes of a word
      do_start(10'h050, 11'd1);
      send_byte(8'hEE, 0, 1'b0);
      send_byte(8'hEE, 0, 1'b0);
      send_byte(8'hEE, 0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6 busy", 32'(bus.busy), 32'd0);
      chk("t6 done", 32'(bus.done), 32'd0);
      chk("t6 mem050 kept", mem[10'h050], 32'h5A5A5A5A);
      tick();
      do_start(10'h050, 11'd1);
      send_word(32'hD4C3B2A1, 1'b0);
      wait_done();
      chk("t6 mem050", mem[10'h050], 32'hD4C3B2A1);
      client_read(10'h050, 32'hD4C3B2A1, "t6 rd050");

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
